uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver for the uvSensor UART link: 8N1, LSB first, line idles high.
//   Oversamples rx with the system clock, centres each bit, and delivers bytes as
//   data + a one-cycle rcv strobe.
//   Receive-side counterpart of the block's transmitter; shares its baud constants.
// PARAMETERS
//   BAUD  434  clk cycles per bit (50 MHz / 115200); even value >= 8; HALF = BAUD/2
// PORTS
//   clk    in   1  system clock, all logic on posedge
//   rst    in   1  asynchronous reset, active high
//   rx     in   1  serial input, asynchronous to clk
//   data   out  8  last correctly framed byte; held until next good frame
//   rcv    out  1  one-cycle pulse: data updated this cycle
//   ferr   out  1  one-cycle pulse: stop bit sampled low (framing error)
//   busy   out  1  high while a frame is in progress (any state but IDLE)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, data=8'h00, rcv=0, ferr=0, busy=0;
//     sync FFs=1, bit counter=0, baud counter=0. Applies mid-frame: partial byte dropped.
//   Input sync: rx -> 2 FFs -> rx_s, 2-cycle latency. All decisions use rx_s only.
//   Baud counter: cleared on every state entry and after every sample. Increments each clk.
//     Enabled only outside IDLE.
//   States:
//     IDLE    : rx_s==0 -> START; else stay.
//     START   : at count HALF-1 sample rx_s. If 0 -> DATA (bitc=0). If 1 -> IDLE.
//               The 1 case is glitch rejection: no strobe, no flag.
//     DATA    : every BAUD cycles sample rx_s into shift[7] and shift right. bitc++.
//               After the 8th sample -> STOP.
//     STOP    : after BAUD cycles sample rx_s.
//               If 1: data<=shift, rcv=1 next cycle, -> IDLE.
//               If 0: ferr=1 next cycle, data unchanged, -> WAITHI.
//     WAITHI  : stay until rx_s==1 (break/line-low guard), then -> IDLE. No new frame starts here.
//   Sample timing: first sample HALF cycles after falling edge of rx_s. Each later sample is
//     BAUD cycles after the previous one (mid-bit). Stop sample ~9.5 bit times after edge.
//   Latency: rcv rises 1 clk after the stop sample, i.e. ~9.5*BAUD+3 clks after the rx falling edge.
//   Back-to-back frames: return to IDLE at mid-stop. A start edge arriving >=1 clk later is accepted.
//     Minimum 1 stop bit suffices.
//   rcv and ferr are mutually exclusive and never high for more than 1 cycle.
//     Outputs are registered.
//   No receive buffer: consumer must take data before next rcv (>=10*BAUD clks later).
// TESTING (sim with BAUD=16, bit time 16 clks)
//   1. Frame 0x55, 1 stop -> single rcv pulse, data=8'h55, ferr=0, busy high for
//      ~152+3 clks then low.
//   2. rx low pulse of 3 clks in idle -> no rcv, no ferr, busy returns 0 after
//      HALF sample; data unchanged.
//   3. Frame 0xA3 with stop bit driven 0, rx held low 40 more clks -> ferr pulse once,
//      no rcv, data keeps previous 8'h55, busy stays 1 until rx high.
//   4. Back-to-back 0x00 then 0xFF, no idle gap -> two rcv pulses 160 clks apart,
//      data=8'h00 then 8'hFF.
//   5. rst asserted at bit 4 of 0x3C, released, then 0xC3 sent -> no rcv for 0x3C,
//      outputs 0 during reset, next rcv has data=8'hC3.
//   6. Bit period skewed +/-4% on 0x96 -> data=8'h96, ferr=0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling from a baud counter,
// registered byte output with one-cycle rcv / ferr strobes.
module uart_rx #(
  parameter int BAUD = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  localparam int HALF = BAUD / 2;
  localparam int CW   = $clog2(BAUD);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHI
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitc_q, bitc_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rcv_q, rcv_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CNT_ONE;
    bitc_d  = bitc_q;
    shift_d = shift_q;
    data_d  = data_q;
    rcv_d   = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      // A start bit that is high again at mid-bit was only a glitch.
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            bitc_d  = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BAUD_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bitc_d  = bitc_q + 3'd1;
          if (bitc_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == BAUD_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            rcv_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAITHI;
          end
        end
      end
      // A held-low line (break) must go high before another start edge counts.
      WAITHI: begin
        if (rx_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bitc_q  <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitc_q  <= bitc_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rcv_q   <= rcv_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data = data_q;
  assign rcv  = rcv_q;
  assign ferr = ferr_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD=16: a stimulus thread queues expected frames,
// a negedge monitor pops and compares them whenever rcv or ferr fires.
module tb_uart_rx;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] byte_val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   rcv_cycles[$];
  int   assert_count = 0;
  int   fail_count   = 0;
  int   cycle        = 0;
  int   start_cycle;
  int   n0;
  logic rcv_prev     = 1'b0;
  logic ferr_prev    = 1'b0;

  uart_rx #(.BAUD(BAUD)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if ((rcv && rcv_prev) || (ferr && ferr_prev) || (rcv && ferr)) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL strobe_shape: rcv=%0b ferr=%0b prev_rcv=%0b prev_ferr=%0b",
                 rcv, ferr, rcv_prev, ferr_prev);
      end
      if (rcv || ferr) begin
        if (exp_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL unexpected_strobe: rcv=%0b ferr=%0b data=%h, expected no strobe",
                   rcv, ferr, data);
        end else begin
          mon_exp = exp_q.pop_front();
          check_output("scoreboard", {6'b0, ferr, rcv, data},
                       {6'b0, mon_exp.is_err, !mon_exp.is_err, mon_exp.byte_val});
        end
        if (rcv) rcv_cycles.push_back(cycle);
      end
    end
    rcv_prev  = rcv;
    ferr_prev = ferr;
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Sends start, 8 data bits LSB first and a stop bit; bit_x100 is the bit time in
  // hundredths of a clock so skewed baud rates accumulate realistically. rx is left
  // at the stop level.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_lvl, input int bit_x100);
    int         edge_prev = 0;
    int         edge_next;
    logic [9:0] bits = {stop_lvl, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      edge_next = ((k + 1) * bit_x100 + 50) / 100;
      drive_bit(bits[k], edge_next - edge_prev);
      edge_prev = edge_next;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] partial;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_state", {5'b0, busy, ferr, rcv, data}, 16'h0000);
    rst = 1'b0;
    idle(10);

    // 1: nominal frame, plus exact rcv latency from the rx falling edge
    exp_q.push_back('{1'b0, 8'h55});
    start_cycle = cycle;
    n0 = rcv_cycles.size();
    apply_stimulus(8'h55, 1'b1, 1600);
    idle(10);
    check_output("frame55_idle", {7'b0, busy, data}, {8'h00, 8'h55});
    if (rcv_cycles.size() > n0)
      check_output("frame55_latency", 16'(rcv_cycles[n0] - start_cycle), 16'd155);
    else
      check_output("frame55_latency_seen", 16'(rcv_cycles.size()), 16'(n0 + 1));

    // 2: short low glitch rejected at the half-bit sample
    drive_bit(1'b0, 3);
    idle(2);
    check_output("glitch_busy", {15'b0, busy}, 16'h0001);
    idle(16);
    check_output("glitch_idle", {7'b0, busy, data}, {8'h00, 8'h55});

    // 3: framing error with line held low afterwards
    exp_q.push_back('{1'b1, 8'h55});
    apply_stimulus(8'hA3, 1'b0, 1600);
    drive_bit(1'b0, 40);
    check_output("ferr_hold", {7'b0, busy, data}, {8'h01, 8'h55});
    check_output("ferr_seen", 16'(exp_q.size()), 16'd0);
    idle(6);
    check_output("ferr_release", {15'b0, busy}, 16'h0000);
    idle(10);

    // 4: back-to-back frames with no idle gap
    exp_q.push_back('{1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'hFF});
    n0 = rcv_cycles.size();
    apply_stimulus(8'h00, 1'b1, 1600);
    apply_stimulus(8'hFF, 1'b1, 1600);
    idle(20);
    if (rcv_cycles.size() >= n0 + 2)
      check_output("b2b_spacing", 16'(rcv_cycles[n0 + 1] - rcv_cycles[n0]), 16'd160);
    else
      check_output("b2b_count", 16'(rcv_cycles.size() - n0), 16'd2);
    check_output("b2b_data", {8'h00, data}, 16'h00FF);

    // 5: reset in the middle of 0x3C drops the partial byte
    partial = 8'h3C;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], 16);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_output("reset_mid_frame", {5'b0, busy, ferr, rcv, data}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    exp_q.push_back('{1'b0, 8'hC3});
    apply_stimulus(8'hC3, 1'b1, 1600);
    idle(20);
    check_output("after_reset_data", {8'h00, data}, 16'h00C3);

    // 6: +/-4% bit-time skew
    exp_q.push_back('{1'b0, 8'h96});
    apply_stimulus(8'h96, 1'b1, 1664);
    idle(20);
    exp_q.push_back('{1'b0, 8'h96});
    apply_stimulus(8'h96, 1'b1, 1536);
    idle(20);
    check_output("skew_data", {7'b0, busy, data}, {8'h00, 8'h96});

    check_output("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
